// File: rtl/sprite_plotter_pkg.sv
// Shared definitions for the sprite plotter: object field layout, screen size
// and FSM state encoding.
package sprite_plotter_pkg;

  localparam int OBJ_W = 18;
  localparam int X_MSB = 17;
  localparam int X_LSB = 10;
  localparam int Y_MSB = 9;
  localparam int Y_LSB = 3;
  localparam int C_MSB = 2;
  localparam int C_LSB = 0;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLOT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef logic [OBJ_W-1:0] obj_t;

endpackage

// File: rtl/sprite_plotter_if.sv
// Request/pixel bus between the game model, the sprite plotter and the VGA adapter.
interface sprite_plotter_if;
  import sprite_plotter_pkg::*;

  logic       draw;
  obj_t       obj;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       plot;
  logic       busy;
  logic       done;
  logic       overflow;

  modport slave (
    input  draw, obj,
    output vga_x, vga_y, vga_colour, plot, busy, done, overflow
  );

  modport master (
    output draw, obj,
    input  vga_x, vga_y, vga_colour, plot, busy, done, overflow
  );
endinterface

// File: rtl/sprite_plotter_counter.sv
// Raster counter for one sprite: dx runs inner, dy outer; last flags the
// final pixel position.
module sprite_plotter_counter #(
  parameter int SPRITE_W = 4,
  parameter int SPRITE_H = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [2:0] dx,
  output logic [2:0] dy,
  output logic       last
);

  localparam logic [2:0] DX_MAX = 3'(SPRITE_W - 1);
  localparam logic [2:0] DY_MAX = 3'(SPRITE_H - 1);

  logic [2:0] dx_q, dx_d;
  logic [2:0] dy_q, dy_d;

  always_comb begin
    dx_d = dx_q;
    dy_d = dy_q;
    if (clr) begin
      dx_d = 3'd0;
      dy_d = 3'd0;
    end else if (en) begin
      if (dx_q == DX_MAX) begin
        dx_d = 3'd0;
        dy_d = (dy_q == DY_MAX) ? 3'd0 : dy_q + 3'd1;
      end else begin
        dx_d = dx_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dx_q <= 3'd0;
      dy_q <= 3'd0;
    end else begin
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign dx   = dx_q;
  assign dy   = dy_q;
  assign last = (dx_q == DX_MAX) && (dy_q == DY_MAX);

endmodule

// File: rtl/sprite_plotter.sv
// Sprite plotter: FSM, active/pending object buffers and registered pixel outputs.
// Optional screen clipping is enabled by defining SPRITE_PLOTTER_CLIP_EN.
module sprite_plotter
  import sprite_plotter_pkg::*;
#(
  parameter int SPRITE_W = 4,
  parameter int SPRITE_H = 4
) (
  input  logic              clock,
  input  logic              reset,
  sprite_plotter_if.slave   bus
);

  state_t     state_q, state_d;
  obj_t       act_q, act_d;
  obj_t       pend_q, pend_d;
  logic       pend_vld_q, pend_vld_d;
  logic       ovf_q, ovf_d;
  logic       plot_q, plot_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic [7:0] vx_q, vx_d;
  logic [6:0] vy_q, vy_d;
  logic [2:0] vc_q, vc_d;

  logic [2:0] dx, dy;
  logic       last;
  logic       cnt_clr, cnt_en;

  logic [7:0] ax;
  logic [6:0] ay;
  logic [2:0] ac;
  logic [7:0] px;
  logic [6:0] py;
  logic       on_scr;

  assign ax = act_q[X_MSB:X_LSB];
  assign ay = act_q[Y_MSB:Y_LSB];
  assign ac = act_q[C_MSB:C_LSB];

  assign cnt_clr = (state_q == ST_LOAD);
  assign cnt_en  = (state_q == ST_PLOT);

  sprite_plotter_counter #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H)
  ) u_counter (
    .clk  (clock),
    .rst  (reset),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .dx   (dx),
    .dy   (dy),
    .last (last)
  );

  // Coordinates wrap in their native widths; clipping looks at the unwrapped sum.
  assign px = ax + {5'd0, dx};
  assign py = ay + {4'd0, dy};

`ifdef SPRITE_PLOTTER_CLIP_EN
  logic [8:0] ux;
  logic [7:0] uy;
  assign ux     = {1'b0, ax} + {6'd0, dx};
  assign uy     = {1'b0, ay} + {5'd0, dy};
  assign on_scr = (ux < 9'(SCREEN_W)) && (uy < 8'(SCREEN_H));
`else
  assign on_scr = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ovf_d      = ovf_q;
    plot_d     = 1'b0;
    done_d     = 1'b0;
    vx_d       = vx_q;
    vy_d       = vy_q;
    vc_d       = vc_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.draw) begin
          act_d   = bus.obj;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_PLOT;
      end
      ST_PLOT: begin
        plot_d = on_scr;
        vx_d   = px;
        vy_d   = py;
        vc_d   = ac;
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_d = 1'b1;
        // A draw arriving in DONE with nothing pending is serviced straight away.
        if (pend_vld_q) begin
          act_d      = pend_q;
          pend_d     = '0;
          pend_vld_d = 1'b0;
          state_d    = ST_LOAD;
        end else if (bus.draw) begin
          act_d   = bus.obj;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.draw && (state_q != ST_IDLE)) begin
      if (pend_vld_q) begin
        ovf_d = 1'b1;
      end else if (state_q != ST_DONE) begin
        pend_d     = bus.obj;
        pend_vld_d = 1'b1;
      end
    end

    busy_d = (state_d != ST_IDLE) || pend_vld_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      act_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
      plot_q     <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      vx_q       <= 8'd0;
      vy_q       <= 7'd0;
      vc_q       <= 3'd0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ovf_q      <= ovf_d;
      plot_q     <= plot_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      vx_q       <= vx_d;
      vy_q       <= vy_d;
      vc_q       <= vc_d;
    end
  end

  assign bus.vga_x      = vx_q;
  assign bus.vga_y      = vy_q;
  assign bus.vga_colour = vc_q;
  assign bus.plot       = plot_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_sprite_plotter.sv
// Scoreboard bench for sprite_plotter: the model pushes every expected pixel when
// a draw is issued and the monitor pops/compares on each plot.
module tb_sprite_plotter;
  import sprite_plotter_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sprite_plotter_if bus();

  sprite_plotter #(.SPRITE_W(W), .SPRITE_H(H)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int plot_cnt = 0;

  logic [17:0] exp_q[$];
  int          plot_cyc_q[$];
  int          done_cyc_q[$];
  logic        busy_at_done_q[$];
  logic [17:0] mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.plot) begin
        plot_cnt++;
        plot_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("plot_with_empty_scoreboard", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pixel", {14'd0, bus.vga_x, bus.vga_y, bus.vga_colour}, {14'd0, mon_e});
        end
      end
      if (bus.done) begin
        done_cyc_q.push_back(cyc);
        busy_at_done_q.push_back(bus.busy);
      end
    end
  end

  task automatic push_sprite(input logic [17:0] o, output int n);
    int ux, uy;
    bit on;
    n = 0;
    for (int dy = 0; dy < H; dy++) begin
      for (int dx = 0; dx < W; dx++) begin
        ux = int'(o[17:10]) + dx;
        uy = int'(o[9:3]) + dy;
        on = 1'b1;
`ifdef SPRITE_PLOTTER_CLIP_EN
        on = (ux < 160) && (uy < 120);
`endif
        if (on) begin
          exp_q.push_back({8'(ux), 7'(uy), o[2:0]});
          n++;
        end
      end
    end
  endtask

  task automatic do_draw(input logic [17:0] o, output int d);
    bus.draw = 1'b1;
    bus.obj  = o;
    @(negedge clk);
    d = cyc;
    bus.draw = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!bus.busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic clr_trk();
    plot_cnt = 0;
    plot_cyc_q.delete();
    done_cyc_q.delete();
    busy_at_done_q.delete();
  endtask

  function automatic int first_of(input int q[$], input int idx);
    return (q.size() > idx) ? q[idx] : -100000;
  endfunction

  task automatic run_basic(input string tag);
    int d, n;
    logic [17:0] o;
    clr_trk();
    o = 18'b010100001001111001;
    push_sprite(o, n);
    do_draw(o, d);
    wait_idle(100);
    chk({tag, "_plots"}, 32'(plot_cnt), 32'd16);
    chk({tag, "_first_plot_lat"}, 32'(first_of(plot_cyc_q, 0) - d), 32'd2);
    chk({tag, "_last_plot_lat"}, 32'(first_of(plot_cyc_q, 15) - d), 32'd17);
    chk({tag, "_done_cnt"}, 32'(done_cyc_q.size()), 32'd1);
    chk({tag, "_done_lat"}, 32'(first_of(done_cyc_q, 0) - d), 32'd18);
    chk({tag, "_busy_at_done"}, 32'((busy_at_done_q.size() > 0) ? busy_at_done_q[0] : 1'b1), 32'd0);
    chk({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, d2, d3, n, nexp;
    logic [17:0] oa, ob, oc, o;
    bit hit;

    bus.draw = 1'b0;
    bus.obj  = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_plot",     32'(bus.plot),       32'd0);
    chk("rst_done",     32'(bus.done),       32'd0);
    chk("rst_busy",     32'(bus.busy),       32'd0);
    chk("rst_overflow", 32'(bus.overflow),   32'd0);
    chk("rst_vga_x",    32'(bus.vga_x),      32'd0);
    chk("rst_vga_y",    32'(bus.vga_y),      32'd0);
    chk("rst_colour",   32'(bus.vga_colour), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_basic("basic");

    // Back-to-back: second request lands in pending three cycles later
    clr_trk();
    oa = {8'd10, 7'd20, 3'd3};
    ob = {8'd100, 7'd50, 3'd6};
    push_sprite(oa, n);
    push_sprite(ob, n);
    do_draw(oa, d1);
    repeat (2) @(negedge clk);
    do_draw(ob, d2);
    chk("b2b_draw_gap", 32'(d2 - d1), 32'd3);
    wait_idle(200);
    chk("b2b_plots", 32'(plot_cnt), 32'd32);
    chk("b2b_done_cnt", 32'(done_cyc_q.size()), 32'd2);
    chk("b2b_second_first_plot", 32'(first_of(plot_cyc_q, 16) - first_of(done_cyc_q, 0)), 32'd2);
    chk("b2b_done_spacing", 32'(first_of(done_cyc_q, 1) - first_of(done_cyc_q, 0)), 32'd18);
    chk("b2b_busy_at_first_done", 32'((busy_at_done_q.size() > 0) ? busy_at_done_q[0] : 1'b0), 32'd1);
    chk("b2b_overflow", 32'(bus.overflow), 32'd0);

    // Overflow: three consecutive draws, the third is dropped
    clr_trk();
    oa = {8'd30, 7'd40, 3'd2};
    ob = {8'd60, 7'd70, 3'd4};
    oc = {8'd90, 7'd100, 3'd7};
    push_sprite(oa, n);
    push_sprite(ob, n);
    do_draw(oa, d1);
    do_draw(ob, d2);
    do_draw(oc, d3);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    wait_idle(200);
    chk("ovf_plots", 32'(plot_cnt), 32'd32);
    chk("ovf_done_cnt", 32'(done_cyc_q.size()), 32'd2);
    repeat (5) @(negedge clk);
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("ovf_cleared_by_reset", 32'(bus.overflow), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Clip corner near the screen edge
    clr_trk();
    o = {8'd158, 7'd118, 3'd5};
    push_sprite(o, n);
    do_draw(o, d1);
    wait_idle(100);
`ifdef SPRITE_PLOTTER_CLIP_EN
    nexp = 4;
`else
    nexp = 16;
`endif
    chk("clip_plots", 32'(plot_cnt), 32'(nexp));
    chk("clip_done_lat", 32'(first_of(done_cyc_q, 0) - d1), 32'd18);

    // Coordinate wrap at 256/128
    clr_trk();
    o = {8'd254, 7'd126, 3'd1};
    push_sprite(o, n);
    do_draw(o, d1);
    wait_idle(100);
    chk("wrap_plots", 32'(plot_cnt), 32'(n));
    chk("wrap_done_lat", 32'(first_of(done_cyc_q, 0) - d1), 32'd18);

    for (int i = 0; i < 3; i++) begin
      clr_trk();
      o = 18'($urandom);
      push_sprite(o, n);
      do_draw(o, d1);
      wait_idle(100);
      chk("rand_plots", 32'(plot_cnt), 32'(n));
      chk("rand_done_lat", 32'(first_of(done_cyc_q, 0) - d1), 32'd18);
    end

    // Reset in the middle of a sprite
    clr_trk();
    o = 18'b010100001001111001;
    push_sprite(o, n);
    do_draw(o, d1);
    hit = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      #1;
      if (plot_cnt >= 5) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) chk("midrst_reach_5th_plot", 32'(plot_cnt), 32'd5);
    rst = 1'b1;
    #1;
    chk("midrst_plot", 32'(bus.plot), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("midrst_no_more_plots", 32'(plot_cnt), 32'd5);
    chk("midrst_no_done", 32'(done_cyc_q.size()), 32'd0);

    run_basic("after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_plotter.md
SPRITE_PLOTTER -- requirements
Module: sprite_plotter

Interface
REQ-001 SHALL have parameter SPRITE_W, default 4, sprite width in pixels (legal 1..8).
REQ-002 SHALL have parameter SPRITE_H, default 4, sprite height in pixels (legal 1..8).
REQ-003 SHALL have port clock  in  1  single system clock; all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port draw  in  1  one-cycle request strobe from the model.
REQ-006 SHALL have port obj  in  18  packed object {x[17:10], y[9:3], colour[2:0]}.
REQ-007 SHALL have port vga_x  out  8  pixel column to the VGA adapter.
REQ-008 SHALL have port vga_y  out  7  pixel row to the VGA adapter.
REQ-009 SHALL have port vga_colour  out  3  pixel colour.
REQ-010 SHALL have port plot  out  1  pixel write enable, valid with vga_x/y/colour in the same cycle.
REQ-011 SHALL have port busy  out  1  high whenever a sprite is loading or plotting, or a request is pending.
REQ-012 SHALL have port done  out  1  one-cycle pulse after the last pixel of each sprite.
REQ-013 SHALL have port overflow  out  1  sticky flag: a request was dropped.

Function
REQ-014 SHALL implement states IDLE, LOAD, PLOT, DONE.
REQ-015 IDLE: draw=1 SHALL capture obj into the active register and go to LOAD next cycle.
REQ-016 LOAD: SHALL clear dx, dy to 0; SHALL go to PLOT.
REQ-017 PLOT: SHALL emit exactly one pixel per cycle, raster order: dx inner (0..SPRITE_W-1), dy outer (0..SPRITE_H-1).
REQ-018 vga_x SHALL be x+dx mod 256, vga_y SHALL be y+dy mod 128, and vga_colour SHALL be the captured colour.
REQ-019 After the pixel with dx=SPRITE_W-1 and dy=SPRITE_H-1, SHALL go to DONE; DONE SHALL assert done for one cycle.
REQ-020 Latency: draw sampled at edge N gives the first plot in cycle N+2, the last plot in cycle N+1+W*H, and done in cycle N+2+W*H.
REQ-021 DONE SHALL go to LOAD if the pending buffer is full (promote pending to active, clear pending), else to IDLE.
REQ-022 Pending buffer SHALL be one entry; draw while not IDLE and pending empty SHALL capture obj into pending.
REQ-023 draw while pending is full SHALL drop obj and set overflow; overflow SHALL clear only on reset.
REQ-024 draw in DONE with pending empty SHALL be captured into pending and serviced next (DONE->LOAD).
REQ-025 draw in DONE with pending full SHALL be dropped, set overflow, and promote the existing pending entry.
REQ-026 plot SHALL be 0 outside PLOT; vga_x/y/colour SHALL hold their last values outside PLOT.
REQ-027 Sprite timing SHALL be independent of obj contents (every pixel cycle is consumed).

Reset
REQ-028 reset SHALL asynchronously force IDLE, pending empty, and active/pending registers to 0.
REQ-029 reset SHALL force plot=0, done=0, busy=0, overflow=0, vga_x=0, vga_y=0, vga_colour=0.
REQ-030 reset mid-sprite SHALL abandon the sprite with no further plot or done pulse.

Configuration
REQ-031 With macro SPRITE_PLOTTER_CLIP_EN defined, pixels with unwrapped x+dx>=160 or y+dy>=120 SHALL have plot=0, still consume their cycle, and vga_x/y SHALL show wrapped values.
REQ-032 Without SPRITE_PLOTTER_CLIP_EN, every PLOT cycle SHALL assert plot with wrapped coordinates.

Structure
REQ-033 A shared package SHALL hold obj field positions (X_MSB=17, X_LSB=10, Y_MSB=9, Y_LSB=3, C_MSB=2, C_LSB=0), SCREEN_W=160, SCREEN_H=120 and the state encoding.
REQ-034 One sub-module, sprite_plotter_counter, SHALL hold the dx/dy raster counter and the last-pixel flag; the FSM and buffers SHALL stay in sprite_plotter.

Verification
REQ-035 Basic: draw with obj=18'b010100001001111001 -> 16 plots, (80,79)..(83,82) raster order, colour 1; done 18 cycles after draw; busy low after done.
REQ-036 Back-to-back: second draw 3 cycles after the first -> pending captured; DONE->LOAD; second sprite's first plot 2 cycles after the first done; overflow stays 0.
REQ-037 Overflow: three draws on consecutive cycles -> first and second sprites plotted, third dropped, overflow=1 until reset.
REQ-038 Clip: x=158, y=118 with CLIP_EN -> plot only at (158..159,118..119) (4 pixels), still 16 PLOT cycles; without CLIP_EN -> 16 plots, x wraps at 160..161 are not wrapped (8-bit), y=120..121 emitted.
REQ-039 Reset mid-sprite: reset asserted after the 5th plot -> plot, done, busy immediately 0; a subsequent draw behaves as in REQ-035.
